mem_arbiter_rr: RTL and testbench
=================================

// Module: mem_arbiter_rr
// PURPOSE
// N-port arbiter sharing one memory port between requesters (I$, D$, later DMA/second core).
// Generalises the 2-port I$/D$ arbiter: NUM_PORTS channels, registered grant, hold-until-done
// ownership, round-robin or fixed-priority mode. Sits between the caches and main memory.
// PARAMETERS
// NUM_PORTS      2   requester count, >=2
// ADDRESS_WIDTH  32  address width
// DATA_WIDTH     32  write-data width
// RR_MODE        1   1 = round-robin; 0 = fixed priority, port 0 highest
// PORTS
// clk            in   1                      clock, rising edge
// reset          in   1                      async, active-high
// req            in   NUM_PORTS              per-port request; held until its done pulse
// write          in   NUM_PORTS              per-port write enable
// size           in   data_size_e[NUM_PORTS] per-port access size
// addr           in   [NUM_PORTS][ADDRESS_WIDTH] per-port address
// wdata          in   [NUM_PORTS][DATA_WIDTH]    per-port write data
// grant          out  NUM_PORTS              one-hot owner, registered
// done           out  NUM_PORTS              one-cycle pulse on owner when mem_ready seen
// mem_req        out  1                      request to memory
// mem_write      out  1                      muxed write
// data_size      out  data_size_e            muxed size
// mem_addr       out  ADDRESS_WIDTH          muxed address
// mem_data       out  DATA_WIDTH             muxed write data
// mem_ready      in   1                      memory completes current transaction this cycle
// BEHAVIOUR
// - Reset (async): state=IDLE, grant=0, done=0, mem_req=0, rr_ptr=0. Mux outputs follow port 0 (0 when idle).
// - OWNER_W = $clog2(NUM_PORTS); owner and rr_ptr are OWNER_W bits; rr_ptr wraps NUM_PORTS-1 -> 0.
// - FSM IDLE:
//   - if |req: winner = first set req scanning from rr_ptr upward with wrap (RR_MODE=1),
//     or lowest index (RR_MODE=0).
//   - Next edge: owner<=winner, grant<=onehot(winner), state<=BUSY.
//   - Grant latency 1 cycle from req.
// - FSM BUSY:
//   - mem_req=1; mem_write/data_size/mem_addr/mem_data combinationally from owner's live inputs.
//   - mem_ready=1 -> done[owner]=1 this cycle (combinational), next edge grant<=0, state<=IDLE,
//     rr_ptr<=owner+1 (wrap).
//   - req[owner] dropped before mem_ready (abort) -> next edge grant<=0, IDLE, rr_ptr<=owner+1, no done.
//   - req changes on non-owners are ignored in BUSY; no pre-emption.
// - One IDLE bubble between transactions: mem_ready and pending reqs -> re-arbitrate in IDLE next cycle.
// - mem_ready in IDLE is ignored; done stays 0.
// - mem_req only when grant!=0; grant always one-hot or zero.
// - Reset mid-BUSY: immediate return to reset values; the transaction is dropped and memory must be reset too.
// - Requester contract: write/size/addr/wdata stable while granted; deassert req the cycle after done.
// TESTING
// 1 Reset: reset=1 with req=all-ones -> grant=0, mem_req=0, done=0 throughout; after release grant=0001 next edge (NUM_PORTS=4).
// 2 Single req: req=0100, mem_ready at 3rd BUSY cycle -> grant=0100 1 cycle after req, mem_addr=addr[2],
//   done=0100 for exactly 1 cycle, grant=0 next edge.
// 3 RR fairness: req held 1111, mem_ready every BUSY cycle -> grant order 0,1,2,3,0; each BUSY separated by 1 IDLE cycle.
// 4 Fixed priority: RR_MODE=0, req=1111 -> port 0 always wins; port 3 granted only after req[2:0]=0.
// 5 Abort: owner 1 drops req mid-BUSY -> grant=0 next edge, no done, next winner port 2 with req=1101.
// 6 Reset mid-op: reset pulsed in BUSY with mem_req=1 -> grant/mem_req 0 same cycle, rr_ptr=0 afterwards.

Source files
------------

// File: rtl/mem_arbiter_rr.sv
// Shares one memory port between NUM_PORTS requesters. Grants are registered, and an owner keeps
// the port until memory completes or the owner aborts. Arbitration is round-robin or fixed priority.
package mem_arbiter_rr_pkg;
  typedef enum logic [1:0] {
    SizeByte = 2'd0,
    SizeHalf = 2'd1,
    SizeWord = 2'd2
  } data_size_e;
endpackage

module mem_arbiter_rr
  import mem_arbiter_rr_pkg::*;
#(
  parameter int unsigned NUM_PORTS     = 2,
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter bit          RR_MODE       = 1'b1
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic       [NUM_PORTS-1:0]                req,
  input  logic       [NUM_PORTS-1:0]                write,
  input  data_size_e [NUM_PORTS-1:0]                size,
  input  logic       [NUM_PORTS-1:0][ADDRESS_WIDTH-1:0] addr,
  input  logic       [NUM_PORTS-1:0][DATA_WIDTH-1:0]    wdata,
  output logic       [NUM_PORTS-1:0]                grant,
  output logic       [NUM_PORTS-1:0]                done,
  output logic                                      mem_req,
  output logic                                      mem_write,
  output data_size_e                                data_size,
  output logic       [ADDRESS_WIDTH-1:0]            mem_addr,
  output logic       [DATA_WIDTH-1:0]               mem_data,
  input  logic                                      mem_ready
);

  localparam int unsigned OwnerW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [OwnerW-1:0] LastPort = OwnerW'(NUM_PORTS - 1);

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } state_e;

  state_e                state_q, state_d;
  logic [NUM_PORTS-1:0]  grant_q, grant_d;
  logic [OwnerW-1:0]     owner_q, owner_d;
  logic [OwnerW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [OwnerW-1:0]     winner;
  logic [OwnerW-1:0]     owner_next;
  logic                  found;
  int unsigned           cand;
  logic                  busy;

  assign busy = (state_q == StBusy);

  // Scan from rr_ptr (or from port 0 in fixed mode) and take the first requester, with wrap.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = 0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      cand = RR_MODE ? (32'(rr_ptr_q) + i) : i;
      if (cand >= NUM_PORTS) begin
        cand = cand - NUM_PORTS;
      end
      if (!found && req[cand]) begin
        winner = OwnerW'(cand);
        found  = 1'b1;
      end
    end
  end

  assign owner_next = (owner_q == LastPort) ? '0 : owner_q + OwnerW'(1);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          owner_d         = winner;
          grant_d         = '0;
          grant_d[winner] = 1'b1;
          state_d         = StBusy;
        end
      end
      StBusy: begin
        // Completion takes precedence over a same-cycle req drop.
        if (mem_ready || !req[owner_q]) begin
          grant_d  = '0;
          state_d  = StIdle;
          rr_ptr_d = owner_next;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    done          = '0;
    done[owner_q] = busy && mem_ready;
    grant         = grant_q;
    mem_req       = busy;
    mem_write     = busy ? write[owner_q] : 1'b0;
    data_size     = busy ? size[owner_q] : SizeByte;
    mem_addr      = busy ? addr[owner_q] : '0;
    mem_data      = busy ? wdata[owner_q] : '0;
  end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench for mem_arbiter_rr: a round-robin instance and a fixed-priority instance,
// both with four ports, checked with immediate assertions against hand-computed values.
module tb_mem_arbiter_rr;
  import mem_arbiter_rr_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [3:0]            req, req_fp;
  logic [3:0]            write;
  data_size_e [3:0]      size;
  logic [3:0][31:0]      addr, wdata;
  logic                  mem_ready, ready_fp;

  logic [3:0]            grant, done, grant_fp, done_fp;
  logic                  mem_req, mem_write, mem_req_fp, mem_write_fp;
  data_size_e            data_size, data_size_fp;
  logic [31:0]           mem_addr, mem_data, mem_addr_fp, mem_data_fp;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter_rr #(.NUM_PORTS(4), .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .RR_MODE(1'b1)) u_rr (
    .clk(clk), .reset(reset), .req(req), .write(write), .size(size), .addr(addr),
    .wdata(wdata), .grant(grant), .done(done), .mem_req(mem_req), .mem_write(mem_write),
    .data_size(data_size), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready)
  );

  mem_arbiter_rr #(.NUM_PORTS(4), .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .RR_MODE(1'b0)) u_fp (
    .clk(clk), .reset(reset), .req(req_fp), .write(write), .size(size), .addr(addr),
    .wdata(wdata), .grant(grant_fp), .done(done_fp), .mem_req(mem_req_fp),
    .mem_write(mem_write_fp), .data_size(data_size_fp), .mem_addr(mem_addr_fp),
    .mem_data(mem_data_fp), .mem_ready(ready_fp)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] order [5];
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    for (int i = 0; i < 4; i++) begin
      addr[i]  = 32'hA000_0000 | 32'(i);
      wdata[i] = 32'hD000_0000 | 32'(i);
      write[i] = (i % 2) == 0;
      size[i]  = (i == 2) ? SizeHalf : SizeWord;
    end

    // Reset held with every port requesting.
    reset = 1'b1; req = 4'hF; req_fp = 4'h0; mem_ready = 1'b0; ready_fp = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_grant", 64'(grant), 64'h0);
      chk("rst_mem_req", 64'(mem_req), 64'h0);
      chk("rst_done", 64'(done), 64'h0);
    end
    reset = 1'b0;
    tick();
    chk("post_rst_grant", 64'(grant), 64'h1);
    chk("post_rst_mem_req", 64'(mem_req), 64'h1);
    chk("post_rst_addr", 64'(mem_addr), 64'hA000_0000);
    mem_ready = 1'b1;
    #1;
    chk("post_rst_done", 64'(done), 64'h1);
    tick();
    mem_ready = 1'b0; req = 4'h0;
    #1;
    chk("post_rst_release", 64'(grant), 64'h0);
    chk("post_rst_done_clr", 64'(done), 64'h0);

    // Single request on port 2, memory ready on the third busy cycle.
    req = 4'b0100;
    tick();
    chk("single_grant", 64'(grant), 64'h4);
    chk("single_addr", 64'(mem_addr), 64'hA000_0002);
    chk("single_data", 64'(mem_data), 64'hD000_0002);
    chk("single_write", 64'(mem_write), 64'h1);
    chk("single_size", 64'(data_size), 64'(SizeHalf));
    chk("single_done0", 64'(done), 64'h0);
    tick();
    chk("single_hold", 64'(grant), 64'h4);
    tick();
    mem_ready = 1'b1;
    #1;
    chk("single_done", 64'(done), 64'h4);
    chk("single_mem_req", 64'(mem_req), 64'h1);
    tick();
    chk("single_release", 64'(grant), 64'h0);
    chk("idle_ready_no_done", 64'(done), 64'h0);
    chk("idle_no_mem_req", 64'(mem_req), 64'h0);
    mem_ready = 1'b0; req = 4'h0;

    // Round-robin order from a fresh pointer, ready every busy cycle.
    reset = 1'b1;
    #1;
    reset = 1'b0;
    req = 4'hF; mem_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("rr_grant%0d", k), 64'(grant), 64'(order[k]));
      chk($sformatf("rr_done%0d", k), 64'(done), 64'(order[k]));
      tick();
      chk($sformatf("rr_bubble%0d", k), 64'(grant), 64'h0);
    end
    req = 4'h0; mem_ready = 1'b0;

    // Fixed priority: lower ports must be cleared before port 3 wins.
    req_fp = 4'hF; ready_fp = 1'b1;
    tick();
    chk("fp_first", 64'(grant_fp), 64'h1);
    tick();
    chk("fp_bubble", 64'(grant_fp), 64'h0);
    tick();
    chk("fp_again0", 64'(grant_fp), 64'h1);
    tick();
    req_fp = 4'b1110;
    tick();
    chk("fp_port1", 64'(grant_fp), 64'h2);
    tick();
    req_fp = 4'b1100;
    tick();
    chk("fp_port2", 64'(grant_fp), 64'h4);
    tick();
    req_fp = 4'b1000;
    tick();
    chk("fp_port3", 64'(grant_fp), 64'h8);
    tick();
    req_fp = 4'h0; ready_fp = 1'b0;

    // Abort: port 1 drops its request while owning the port.
    req = 4'b0010;
    tick();
    chk("abort_grant", 64'(grant), 64'h2);
    tick();
    chk("abort_hold", 64'(grant), 64'h2);
    req = 4'b1101;
    #1;
    chk("abort_no_done", 64'(done), 64'h0);
    tick();
    chk("abort_release", 64'(grant), 64'h0);
    chk("abort_done_clr", 64'(done), 64'h0);
    tick();
    chk("abort_next", 64'(grant), 64'h4);
    chk("abort_next_req", 64'(mem_req), 64'h1);

    // Reset while busy clears outputs immediately and rewinds the pointer.
    reset = 1'b1;
    #1;
    chk("midrst_grant", 64'(grant), 64'h0);
    chk("midrst_mem_req", 64'(mem_req), 64'h0);
    reset = 1'b0;
    req = 4'hF;
    tick();
    chk("midrst_ptr", 64'(grant), 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
